// File: rtl/datapath_ext_pkg.sv
// Shared types and constants for the extended accumulator datapath.
package datapath_ext_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SHL = 3'b101,
        OP_SHR = 3'b110,
        OP_MUL = 3'b111
    } alu_op_t;

    typedef enum logic [1:0] {
        SEL_ALU     = 2'b00,
        SEL_OPERAND = 2'b01,
        SEL_MEM     = 2'b10,
        SEL_NONE    = 2'b11
    } sel_a_t;

    typedef enum logic [1:0] {
        MS_IDLE = 2'b00,
        MS_MUL  = 2'b01,
        MS_DONE = 2'b10
    } mul_state_t;

    localparam int FLAG_Z     = 0;
    localparam int FLAG_N     = 1;
    localparam int FLAG_C     = 2;
    localparam int FLAG_V     = 3;
    localparam int FLAG_COUNT = 4;

endpackage

// File: rtl/datapath_ext_seq_multiplier.sv
// Unsigned shift-add multiplier, one multiplier bit per cycle, with busy/done handshake.
module seq_multiplier
    import datapath_ext_pkg::*;
#(
    parameter int DATA_WIDTH = 11
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic [DATA_WIDTH-1:0]     a_i,
    input  logic [DATA_WIDTH-1:0]     b_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      last_o,
    output logic [2*DATA_WIDTH-1:0]   product_o
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    mul_state_t      state_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q, done_q;
    logic [2*W-1:0]  prod_q, prod_d, mcand_q;
    logic [W-1:0]    mplier_q;

    // last_o and product_o are the values the final step produces, so the
    // owner can commit the result on the same edge the FSM leaves MUL.
    assign prod_d    = prod_q + (mplier_q[0] ? mcand_q : '0);
    assign last_o    = (state_q == MS_MUL) && (cnt_q == LAST_BIT);
    assign product_o = prod_d;
    assign busy_o    = busy_q;
    assign done_o    = done_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= MS_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                MS_MUL: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_BIT) begin
                        state_q <= MS_DONE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        state_q <= MS_MUL;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= MS_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (start_i && !busy_q) begin
            prod_q   <= '0;
            mcand_q  <= {{W{1'b0}}, a_i};
            mplier_q <= b_i;
        end else if (busy_q) begin
            prod_q   <= prod_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
        end
    end

endmodule

// File: rtl/datapath_ext.sv
// Accumulator bank, extended ALU, Z/N/C/V flag register and multiply write-back arbitration.
module datapath_ext
    import datapath_ext_pkg::*;
#(
    parameter int DATA_WIDTH = 11,
    parameter int ACC_COUNT  = 2,
    localparam int AW = $clog2(ACC_COUNT)
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    input  logic [DATA_WIDTH-1:0] operand_in,
    input  logic [DATA_WIDTH-1:0] data_memory_in,
    input  logic [2:0]            op_alu_in,
    input  logic [1:0]            sel_A_in,
    input  logic                  sel_B_in,
    input  logic [AW-1:0]         acc_sel_in,
    input  logic                  acc_wr_in,
    input  logic                  status_wr_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [DATA_WIDTH-1:0] ext_out,
    output logic [DATA_WIDTH-1:0] data_memory_address_out,
    output logic                  flag_Z_out,
    output logic                  flag_N_out,
    output logic                  flag_C_out,
    output logic                  flag_V_out,
    output logic                  busy_out,
    output logic                  done_out
);
    localparam int W = DATA_WIDTH;

    alu_op_t                 op;
    sel_a_t                  sel_a;
    logic [W-1:0]            acc_q [ACC_COUNT];
    logic [W-1:0]            a_val, b_val, alu_res, wr_data;
    logic signed [W-1:0]     a_s;
    logic [W:0]              wide;
    logic                    alu_c, alu_v;
    logic [FLAG_COUNT-1:0]   alu_flags, mul_flags, flags_q;
    logic                    mul_busy, mul_last, mul_start, acc_wr_en, flag_wr_en;
    logic [2*W-1:0]          mul_prod;
    logic [AW-1:0]           dest_q;
    logic                    flag_latch_q;

    function automatic logic signed_ovf(input logic sa, input logic sb,
                                        input logic sr, input logic is_sub);
        logic sb_eff;
        sb_eff = is_sub ? ~sb : sb;
        return (sa == sb_eff) && (sr != sa);
    endfunction

    assign op    = alu_op_t'(op_alu_in);
    assign sel_a = sel_a_t'(sel_A_in);
    assign a_val = acc_q[acc_sel_in];
    assign a_s   = a_val;
    assign b_val = sel_B_in ? data_memory_in : operand_in;

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        wide    = '0;
        case (op)
            OP_ADD: begin
                wide    = {1'b0, a_val} + {1'b0, b_val};
                alu_res = wide[W-1:0];
                alu_c   = wide[W];
                alu_v   = signed_ovf(a_val[W-1], b_val[W-1], alu_res[W-1], 1'b0);
            end
            OP_SUB: begin
                wide    = {1'b0, a_val} - {1'b0, b_val};
                alu_res = wide[W-1:0];
                alu_c   = wide[W];
                alu_v   = signed_ovf(a_val[W-1], b_val[W-1], alu_res[W-1], 1'b1);
            end
            OP_AND: alu_res = a_val & b_val;
            OP_OR:  alu_res = a_val | b_val;
            OP_XOR: alu_res = a_val ^ b_val;
            OP_SHL: begin
                alu_res = a_val << 1;
                alu_c   = a_val[W-1];
            end
            OP_SHR: begin
                alu_res = a_s >>> 1;
                alu_c   = a_val[0];
            end
            default: alu_res = '0;
        endcase
        alu_flags         = '0;
        alu_flags[FLAG_Z] = (alu_res == '0);
        alu_flags[FLAG_N] = alu_res[W-1];
        alu_flags[FLAG_C] = alu_c;
        alu_flags[FLAG_V] = alu_v;
    end

    always_comb begin
        mul_flags         = '0;
        mul_flags[FLAG_Z] = (mul_prod[W-1:0] == '0);
        mul_flags[FLAG_N] = mul_prod[W-1];
        mul_flags[FLAG_C] = |mul_prod[2*W-1:W];
    end

    always_comb begin
        case (sel_a)
            SEL_OPERAND: wr_data = operand_in;
            SEL_MEM:     wr_data = data_memory_in;
            default:     wr_data = alu_res;
        endcase
    end

    // A multiply start claims the edge: neither accumulators nor flags move on it.
    assign mul_start  = acc_wr_in && (op == OP_MUL) && (sel_a == SEL_ALU) && !mul_busy;
    assign acc_wr_en  = acc_wr_in && !mul_busy && !mul_start && (sel_a != SEL_NONE);
    assign flag_wr_en = status_wr_in && !mul_busy && !mul_start;

    seq_multiplier #(.DATA_WIDTH(W)) u_mul (
        .clk_i     (clock_in),
        .rst_i     (reset_in),
        .start_i   (mul_start),
        .a_i       (a_val),
        .b_i       (b_val),
        .busy_o    (mul_busy),
        .done_o    (done_out),
        .last_o    (mul_last),
        .product_o (mul_prod)
    );

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            for (int i = 0; i < ACC_COUNT; i++) acc_q[i] <= '0;
            flags_q <= '0;
        end else if (mul_last) begin
            acc_q[dest_q] <= mul_prod[W-1:0];
            if (flag_latch_q) flags_q <= mul_flags;
        end else begin
            if (acc_wr_en)  acc_q[acc_sel_in] <= wr_data;
            if (flag_wr_en) flags_q <= alu_flags;
        end
    end

    always_ff @(posedge clock_in) begin
        if (mul_start) begin
            dest_q       <= acc_sel_in;
            flag_latch_q <= status_wr_in;
        end
    end

    assign data_out                = a_val;
    assign ext_out                 = alu_res;
    assign data_memory_address_out = operand_in;
    assign flag_Z_out              = flags_q[FLAG_Z];
    assign flag_N_out              = flags_q[FLAG_N];
    assign flag_C_out              = flags_q[FLAG_C];
    assign flag_V_out              = flags_q[FLAG_V];
    assign busy_out                = mul_busy;

endmodule

// File: tb/tb_datapath_ext.sv
// Directed and randomized bench for datapath_ext at W=11, two accumulators.
module tb_datapath_ext;

    logic        clock_in, reset_in;
    logic [10:0] operand_in, data_memory_in;
    logic [2:0]  op_alu_in;
    logic [1:0]  sel_A_in;
    logic        sel_B_in;
    logic [0:0]  acc_sel_in;
    logic        acc_wr_in, status_wr_in;
    logic [10:0] data_out, ext_out, data_memory_address_out;
    logic        flag_Z_out, flag_N_out, flag_C_out, flag_V_out, busy_out, done_out;

    int checks = 0;
    int errors = 0;
    int m_acc [2];
    logic [3:0] m_flags;

    datapath_ext #(.DATA_WIDTH(11), .ACC_COUNT(2)) dut (
        .clock_in(clock_in), .reset_in(reset_in),
        .operand_in(operand_in), .data_memory_in(data_memory_in),
        .op_alu_in(op_alu_in), .sel_A_in(sel_A_in), .sel_B_in(sel_B_in),
        .acc_sel_in(acc_sel_in), .acc_wr_in(acc_wr_in), .status_wr_in(status_wr_in),
        .data_out(data_out), .ext_out(ext_out),
        .data_memory_address_out(data_memory_address_out),
        .flag_Z_out(flag_Z_out), .flag_N_out(flag_N_out),
        .flag_C_out(flag_C_out), .flag_V_out(flag_V_out),
        .busy_out(busy_out), .done_out(done_out)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] flags_now();
        return {flag_Z_out, flag_N_out, flag_C_out, flag_V_out};
    endfunction

    // Reference ALU on plain integers: two's complement views for V and SHR.
    function automatic void alu_model(input int op, input int a, input int b,
                                      output int res, output bit c, output bit v);
        int sa, sb, s;
        sa = (a >= 1024) ? a - 2048 : a;
        sb = (b >= 1024) ? b - 2048 : b;
        res = 0; c = 0; v = 0;
        case (op)
            0: begin s = a + b; res = s % 2048; c = (s >= 2048);
                     v = (sa + sb > 1023) || (sa + sb < -1024); end
            1: begin res = (a - b + 2048) % 2048; c = (a < b);
                     v = (sa - sb > 1023) || (sa - sb < -1024); end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: begin res = (a * 2) % 2048; c = (a >= 1024); end
            6: begin s = (sa >= 0) ? sa / 2 : -((1 - sa) / 2);
                     res = (s + 2048) % 2048; c = ((a % 2) == 1); end
            default: res = 0;
        endcase
    endfunction

    task automatic single(input int op, input int sa, input int sb, input int sel,
                          input bit wr, input bit swr, input int opnd, input int mem);
        int a, b, res;
        bit c, v;
        op_alu_in = 3'(op); sel_A_in = 2'(sa); sel_B_in = 1'(sb); acc_sel_in = 1'(sel);
        acc_wr_in = wr; status_wr_in = swr;
        operand_in = 11'(opnd); data_memory_in = 11'(mem);
        #2;
        a = m_acc[sel];
        b = sb ? mem : opnd;
        alu_model(op, a, b, res, c, v);
        chk("ext_out", ext_out, res);
        chk("mem_addr", data_memory_address_out, opnd);
        @(posedge clock_in); #1;
        acc_wr_in = 1'b0; status_wr_in = 1'b0;
        if (!(op == 7 && sa == 0 && wr)) begin
            if (wr && sa != 3) m_acc[sel] = (sa == 0) ? res : (sa == 1) ? opnd : mem;
            if (swr) m_flags = {res == 0, res >= 1024, c, v};
        end
        #1;
        chk("data_out", data_out, m_acc[sel]);
        chk("flags", flags_now(), m_flags);
    endtask

    task automatic mul_run(input int sel, input int b, input bit swr, input bit poke, input bit abort);
        int a, n, p, dones;
        a = m_acc[sel];
        op_alu_in = 3'b111; sel_A_in = 2'b00; sel_B_in = 1'b0; acc_sel_in = 1'(sel);
        operand_in = 11'(b); acc_wr_in = 1'b1; status_wr_in = swr;
        #2;
        chk("mul_ext_zero", ext_out, 0);
        @(posedge clock_in); #1;
        acc_wr_in = 1'b0; status_wr_in = 1'b0;
        chk("mul_start_busy", busy_out, 1);
        chk("mul_start_nowrite", data_out, a);
        chk("mul_start_noflags", flags_now(), m_flags);
        n = 0; dones = 0;
        while (busy_out === 1'b1 && n < 40) begin
            n++;
            if (done_out) dones++;
            if (abort && n == 5) begin
                reset_in = 1'b1;
                #1;
                m_acc[0] = 0; m_acc[1] = 0; m_flags = 4'b0000;
                chk("abort_busy_drop", busy_out, 0);
                chk("abort_acc", data_out, 0);
                chk("abort_flags", flags_now(), 4'b0000);
                #2 reset_in = 1'b0;
                break;
            end
            if (poke && n == 3) begin
                acc_sel_in = 1'b1; sel_A_in = 2'b01; operand_in = 11'd7;
                acc_wr_in = 1'b1; status_wr_in = 1'b1;
            end
            if (poke && n == 4) begin
                acc_sel_in = 1'(sel); sel_A_in = 2'b00; acc_wr_in = 1'b0; status_wr_in = 1'b0;
            end
            @(posedge clock_in); #1;
        end
        if (abort) begin
            repeat (15) begin
                @(posedge clock_in); #1;
                if (done_out) dones++;
            end
            chk("abort_no_done", dones, 0);
            chk("abort_idle", busy_out, 0);
            chk("abort_acc_after", data_out, 0);
        end else begin
            chk("mul_busy_cycles", n, 11);
            chk("mul_no_early_done", dones, 0);
            chk("mul_done_pulse", done_out, 1);
            p = a * b;
            m_acc[sel] = p % 2048;
            if (swr) m_flags = {(p % 2048) == 0, (p % 2048) >= 1024, p >= 2048, 1'b0};
            chk("mul_result", data_out, m_acc[sel]);
            chk("mul_flags", flags_now(), m_flags);
            @(posedge clock_in); #1;
            chk("mul_done_once", done_out, 0);
            chk("mul_result_hold", data_out, m_acc[sel]);
        end
    endtask

    initial begin
        int edge_vals [5];
        int op, sa, sb, sel, opnd, mem;
        bit wr, swr;
        edge_vals[0] = 0; edge_vals[1] = 1; edge_vals[2] = 1023;
        edge_vals[3] = 1024; edge_vals[4] = 2047;

        reset_in = 1'b1; operand_in = '0; data_memory_in = '0; op_alu_in = '0;
        sel_A_in = '0; sel_B_in = 1'b0; acc_sel_in = '0; acc_wr_in = 1'b0; status_wr_in = 1'b0;
        m_acc[0] = 0; m_acc[1] = 0; m_flags = 4'b0000;
        repeat (2) @(posedge clock_in);
        #1;
        chk("rst_acc0", data_out, 0);
        acc_sel_in = 1'b1; #1;
        chk("rst_acc1", data_out, 0);
        chk("rst_flags", flags_now(), 4'b0000);
        chk("rst_busy", busy_out, 0);
        chk("rst_done", done_out, 0);
        reset_in = 1'b0;
        @(posedge clock_in); #1;

        single(0, 1, 0, 0, 1, 0, 1023, 0);
        single(0, 0, 0, 0, 1, 1, 1, 0);
        chk("plan_add_acc", data_out, 1024);
        chk("plan_add_flags", flags_now(), 4'b0101);

        single(0, 1, 0, 1, 1, 0, 3, 0);
        single(1, 0, 0, 1, 1, 1, 5, 0);
        chk("plan_sub_acc", data_out, 2046);
        chk("plan_sub_flags", flags_now(), 4'b0110);
        single(0, 1, 0, 0, 1, 0, 5, 0);
        single(1, 0, 1, 0, 1, 1, 0, 5);
        chk("plan_sub_zero_flags", flags_now(), 4'b1000);
        acc_sel_in = 1'b1; #1;
        chk("plan_acc1_kept", data_out, 2046);

        single(0, 1, 0, 0, 1, 0, 12, 0);
        mul_run(0, 13, 1'b1, 1'b0, 1'b0);
        chk("plan_mul_156", data_out, 156);
        chk("plan_mul_156_flags", flags_now(), 4'b0000);

        single(0, 1, 0, 0, 1, 0, 100, 0);
        mul_run(0, 100, 1'b1, 1'b1, 1'b0);
        chk("plan_mul_1808", data_out, 1808);
        chk("plan_mul_1808_flags", flags_now(), 4'b0110);
        acc_sel_in = 1'b1; #1;
        chk("plan_busy_write_ignored", data_out, 2046);

        single(0, 2, 1, 1, 1, 0, 0, 1023);
        single(6, 0, 0, 1, 1, 1, 0, 0);
        single(5, 0, 0, 1, 1, 1, 0, 0);

        for (int i = 0; i < 90; i++) begin
            op   = $urandom_range(0, 7);
            sa   = $urandom_range(0, 3);
            sb   = $urandom_range(0, 1);
            sel  = $urandom_range(0, 1);
            wr   = 1'($urandom_range(0, 1));
            swr  = 1'($urandom_range(0, 1));
            opnd = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom_range(0, 2047);
            mem  = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 4)] : $urandom_range(0, 2047);
            if (op == 7 && sa == 0) wr = 1'b0;
            single(op, sa, sb, sel, wr, swr, opnd, mem);
            if (i % 30 == 29)
                mul_run($urandom_range(0, 1), $urandom_range(0, 2047), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end

        single(0, 1, 0, 0, 1, 0, 9, 0);
        mul_run(0, 7, 1'b1, 1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
